// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type, accumulator sizing and min/max helpers for the convolution IP.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, WRITE, DONE} conv_state_t;
  function automatic int acc_width(int dw, int aw);
    return 2 * dw + aw;
  endfunction
  function automatic int max_i(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int min_i(int a, int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: read-valid delay, multiply-accumulate and Z output formatting.
// Optional CONV_SAT_EN clamps the output to all-ones instead of truncating.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_X_WIDTH = 5,
  parameter int Z_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_x,
  input  logic [DATA_WIDTH-1:0] data_y,
  output logic [Z_WIDTH-1:0]    data_z
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_X_WIDTH);
  logic                    valid;
  logic [ACC_WIDTH-1:0]    acc;
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = {{DATA_WIDTH{1'b0}}, data_x} * {{DATA_WIDTH{1'b0}}, data_y};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      acc   <= '0;
    end else begin
      valid <= rd_en;
      acc   <= clr ? '0 : valid ? acc + ACC_WIDTH'(prod) : acc;
    end
`ifdef CONV_SAT_EN
  assign data_z = |acc[ACC_WIDTH-1:Z_WIDTH] ? '1 : acc[Z_WIDTH-1:0];
`else
  assign data_z = acc[Z_WIDTH-1:0];
`endif
endmodule

// File: rtl/conv_ctrl_mac.sv
// conv_ctrl_mac: convolution sequencer (FSM, n/k counters, busy/done pulses) around conv_mac.
// Define CONV_SAT_EN to saturate data_z instead of truncating it.
module conv_ctrl_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_X_WIDTH = 5,
  parameter int ADDR_Y_WIDTH = 5,
  parameter int ADDR_Z_WIDTH = 6,
  parameter int Z_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_X_WIDTH:0]   size_x,
  input  logic [ADDR_Y_WIDTH:0]   size_y,
  output logic                    rd_en,
  output logic [ADDR_X_WIDTH-1:0] addr_x,
  output logic [ADDR_Y_WIDTH-1:0] addr_y,
  input  logic [DATA_WIDTH-1:0]   data_x,
  input  logic [DATA_WIDTH-1:0]   data_y,
  output logic                    we_z,
  output logic [ADDR_Z_WIDTH-1:0] addr_z,
  output logic [Z_WIDTH-1:0]      data_z,
  output logic                    busy_set,
  output logic                    busy_rst,
  output logic                    done_set,
  output logic                    done_rst,
  output logic                    err
);
  conv_state_t             state;
  logic [ADDR_X_WIDTH:0]   sx;
  logic [ADDR_Y_WIDTH:0]   sy;
  logic [ADDR_Z_WIDTH-1:0] n;
  logic [ADDR_Z_WIDTH-1:0] last_n;
  logic [ADDR_X_WIDTH-1:0] k_hi;
  int                      lo;
  int                      hi;
  always_comb begin
    lo = max_i(0, int'(n) - int'(sy) + 1);
    hi = min_i(int'(n), int'(sx) - 1);
  end
  assign last_n = ADDR_Z_WIDTH'(int'(sx) + int'(sy) - 2);
  // addr_x doubles as k; addr_y tracks n-k so it only ever decrements
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      sx       <= '0;
      sy       <= '0;
      n        <= '0;
      k_hi     <= '0;
      rd_en    <= 1'b0;
      addr_x   <= '0;
      addr_y   <= '0;
      we_z     <= 1'b0;
      addr_z   <= '0;
      busy_set <= 1'b0;
      busy_rst <= 1'b0;
      done_set <= 1'b0;
      done_rst <= 1'b0;
      err      <= 1'b0;
    end else begin
      busy_set <= 1'b0;
      busy_rst <= 1'b0;
      done_set <= 1'b0;
      done_rst <= 1'b0;
      err      <= 1'b0;
      we_z     <= 1'b0;
      case (state)
        IDLE:
          if (start && size_x != '0 && size_y != '0) begin
            sx       <= size_x;
            sy       <= size_y;
            n        <= '0;
            busy_set <= 1'b1;
            done_rst <= 1'b1;
            state    <= INIT;
          end else if (start) begin
            err      <= 1'b1;
            done_set <= 1'b1;
          end
        INIT: begin
          rd_en  <= 1'b1;
          addr_x <= ADDR_X_WIDTH'(lo);
          addr_y <= ADDR_Y_WIDTH'(int'(n) - lo);
          k_hi   <= ADDR_X_WIDTH'(hi);
          state  <= ISSUE;
        end
        ISSUE:
          if (addr_x == k_hi) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            addr_x <= addr_x + 1'b1;
            addr_y <= addr_y - 1'b1;
          end
        DRAIN: begin
          we_z   <= 1'b1;
          addr_z <= n;
          state  <= WRITE;
        end
        WRITE:
          if (n == last_n) begin
            busy_rst <= 1'b1;
            done_set <= 1'b1;
            state    <= DONE;
          end else begin
            n     <= n + 1'b1;
            state <= INIT;
          end
        default: state <= IDLE;
      endcase
    end
  conv_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_X_WIDTH(ADDR_X_WIDTH),
    .Z_WIDTH     (Z_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .clr   (state == INIT),
    .data_x(data_x),
    .data_y(data_y),
    .data_z(data_z)
  );
endmodule
